pipeline_hazard_ctrl: RTL

Central stall/flush controller for the RV32 five-stage pipeline. Watches the ID, EX and MEM stages and generates per-register enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Handles three hazards:
- load-use,
- taken-branch redirect,
- multi-cycle data-memory access with a timeout watchdog.

It also keeps stall and flush performance counters.

---
 rtl/rv32_pipe_pkg.sv | 16 +
 rtl/hazard_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rv32_pipe_pkg.sv
// Purpose: shared types and constants for the RV32 five-stage pipeline control.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package rv32_pipe_pkg;

  // Hazard controller FSM encoding
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } state_t;

  // Architectural zero register: never a real data dependency
  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Purpose: load-use comparator between the load in EX and the operands read in ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides how to stall on lu.
module hazard_detect
  import rv32_pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  // Only operands that ID actually reads can create a dependency; x0 never does
  always_comb begin
    rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    lu      = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush controller for PC and pipeline registers (load-use, branch, dmem wait + watchdog).
// Latency: enables/flushes combinational from state and inputs; halted registered from state.
// Backpressure: dmem_ready low freezes the whole pipe; watchdog halts after TIMEOUT wait cycles.
module pipeline_hazard_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0]      TIMEOUT_W = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        lu;
  logic        mem_stall;
  logic        flush_win;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu          (lu)
  );

  assign mem_stall = mem_access && !dmem_ready;

  // Priority-ordered control: reset, ERROR, memory stall, branch redirect, load-use, normal
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    flush_win    = 1'b0;
    if (reset || state == ERROR) begin
      // everything held, nothing flushed
    end else if (mem_stall) begin
      // Freeze the pipe; bubble into WB so the retiring instruction commits only once
      mem_wb_en    = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // ID and IF hold wrong-path instructions, so this outranks load-use
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_win   = 1'b1;
    end else if (lu) begin
      // Hold PC and IF/ID, insert one bubble into EX
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

  // FSM and watchdog: ready in the timeout cycle wins over entering ERROR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 16'd0;
      halted   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= WAIT;
            wait_cnt <= 16'd1;
          end
        end
        WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
          end else if (wait_cnt < TIMEOUT_W) begin
            wait_cnt <= wait_cnt + 16'd1;
          end else begin
            state  <= ERROR;
            halted <= 1'b1;
          end
        end
        ERROR: begin
          state  <= ERROR;
          halted <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= 16'd0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

  // Performance counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_win) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
